// File: rtl/axi_arb.sv
// axi_arb: shares one AXI-lite master port between the IFU (read only) and
// the LSU (read + write). Only one transaction is ever outstanding.
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-low reset
//   ifu_ar_* / ifu_r_*  : IFU read address / read data channels
//   lsu_ar_* / lsu_r_*  : LSU read address / read data channels
//   lsu_aw_* / lsu_w_*  : LSU write address / write data channels
//   lsu_b_*             : LSU write response channel
//   mst_*               : shared downstream AXI-lite master port
//
// Arbitration: the LSU prefers a write (aw and w both valid) over a read.
// IFU vs LSU is round-robin on last_grant, which resets to LSU so the IFU
// wins the first tie.
module axi_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ifu_ar_valid_i,
  input  logic [ADDR_W-1:0]   ifu_ar_addr_i,
  output logic                ifu_ar_ready_o,
  output logic                ifu_r_valid_o,
  output logic [DATA_W-1:0]   ifu_r_data_o,
  output logic [1:0]          ifu_r_resp_o,
  input  logic                ifu_r_ready_i,
  input  logic                lsu_ar_valid_i,
  input  logic [ADDR_W-1:0]   lsu_ar_addr_i,
  output logic                lsu_ar_ready_o,
  output logic                lsu_r_valid_o,
  output logic [DATA_W-1:0]   lsu_r_data_o,
  output logic [1:0]          lsu_r_resp_o,
  input  logic                lsu_r_ready_i,
  input  logic                lsu_aw_valid_i,
  input  logic [ADDR_W-1:0]   lsu_aw_addr_i,
  output logic                lsu_aw_ready_o,
  input  logic                lsu_w_valid_i,
  input  logic [DATA_W-1:0]   lsu_w_data_i,
  input  logic [DATA_W/8-1:0] lsu_w_strb_i,
  output logic                lsu_w_ready_o,
  output logic                lsu_b_valid_o,
  output logic [1:0]          lsu_b_resp_o,
  input  logic                lsu_b_ready_i,
  output logic                mst_ar_valid_o,
  output logic [ADDR_W-1:0]   mst_ar_addr_o,
  input  logic                mst_ar_ready_i,
  input  logic                mst_r_valid_i,
  input  logic [DATA_W-1:0]   mst_r_data_i,
  input  logic [1:0]          mst_r_resp_i,
  output logic                mst_r_ready_o,
  output logic                mst_aw_valid_o,
  output logic [ADDR_W-1:0]   mst_aw_addr_o,
  input  logic                mst_aw_ready_i,
  output logic                mst_w_valid_o,
  output logic [DATA_W-1:0]   mst_w_data_o,
  output logic [DATA_W/8-1:0] mst_w_strb_o,
  input  logic                mst_w_ready_i,
  input  logic                mst_b_valid_i,
  input  logic [1:0]          mst_b_resp_i,
  output logic                mst_b_ready_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                run_q;   // low for the first cycle after a reset edge
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;

  logic lsu_wr, lsu_req, grant_ifu;

  assign lsu_wr    = lsu_aw_valid_i & lsu_w_valid_i;
  assign lsu_req   = lsu_wr | lsu_ar_valid_i;
  assign grant_ifu = ifu_ar_valid_i & (~lsu_req | (last_q == OWN_LSU));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    addr_d         = addr_q;
    data_d         = data_q;
    strb_d         = strb_q;
    ifu_ar_ready_o = 1'b0;
    lsu_ar_ready_o = 1'b0;
    lsu_aw_ready_o = 1'b0;
    lsu_w_ready_o  = 1'b0;
    ifu_r_valid_o  = 1'b0;
    lsu_r_valid_o  = 1'b0;
    lsu_b_valid_o  = 1'b0;
    mst_ar_valid_o = 1'b0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    mst_r_ready_o  = 1'b0;
    mst_b_ready_o  = 1'b0;
    // Data/resp paths are routed unconditionally; only the valids qualify them.
    ifu_r_data_o   = mst_r_data_i;
    ifu_r_resp_o   = mst_r_resp_i;
    lsu_r_data_o   = mst_r_data_i;
    lsu_r_resp_o   = mst_r_resp_i;
    lsu_b_resp_o   = mst_b_resp_i;
    mst_ar_addr_o  = addr_q;
    mst_aw_addr_o  = addr_q;
    mst_w_data_o   = data_q;
    mst_w_strb_o   = strb_q;

    // Every valid/ready stays low while reset is applied and for one cycle after.
    if (rst_i && run_q) begin
      unique case (state_q)
        IDLE: begin
          if (grant_ifu) begin
            ifu_ar_ready_o = 1'b1;
            addr_d  = ifu_ar_addr_i;
            owner_d = OWN_IFU;
            last_d  = OWN_IFU;
            state_d = RD_ADDR;
          end else if (lsu_wr) begin
            lsu_aw_ready_o = 1'b1;
            lsu_w_ready_o  = 1'b1;
            addr_d    = lsu_aw_addr_i;
            data_d    = lsu_w_data_i;
            strb_d    = lsu_w_strb_i;
            owner_d   = OWN_LSU;
            last_d    = OWN_LSU;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end else if (lsu_ar_valid_i) begin
            lsu_ar_ready_o = 1'b1;
            addr_d  = lsu_ar_addr_i;
            owner_d = OWN_LSU;
            last_d  = OWN_LSU;
            state_d = RD_ADDR;
          end
        end
        RD_ADDR: begin
          mst_ar_valid_o = 1'b1;
          if (mst_ar_ready_i) state_d = RD_DATA;
        end
        RD_DATA: begin
          mst_r_ready_o = (owner_q == OWN_LSU) ? lsu_r_ready_i : ifu_r_ready_i;
          ifu_r_valid_o = mst_r_valid_i & (owner_q == OWN_IFU);
          lsu_r_valid_o = mst_r_valid_i & (owner_q == OWN_LSU);
          if (mst_r_valid_i && mst_r_ready_o) state_d = IDLE;
        end
        WR_REQ: begin
          // aw and w complete independently; each valid drops after its own handshake.
          mst_aw_valid_o = ~aw_done_q;
          mst_w_valid_o  = ~w_done_q;
          aw_done_d = aw_done_q | mst_aw_ready_i;
          w_done_d  = w_done_q | mst_w_ready_i;
          if (aw_done_d && w_done_d) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_RESP;
          end
        end
        WR_RESP: begin
          lsu_b_valid_o = mst_b_valid_i;
          mst_b_ready_o = lsu_b_ready_i;
          if (mst_b_valid_i && lsu_b_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IFU;
      last_q    <= OWN_LSU;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      run_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      run_q     <= 1'b1;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

endmodule
